// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, NOP word
// and the fetch controller state encoding.
package fetch_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding-request
// memory handshake, applies stalls/redirects and feeds the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
  parameter logic [WORD_W-1:0] PC_STEP  = 16'd4,
  parameter logic [WORD_W-1:0] NOP      = NOP_INSTR
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_write,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              jump_en,
  input  logic [WORD_W-1:0] jump_target,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] if_instruction,
  output logic [WORD_W-1:0] if_pc4,
  output logic              if_valid,
  output logic              if_flush
);

  fetch_state_t      state_reg;
  logic [WORD_W-1:0] pc_reg;
  logic [WORD_W-1:0] hold_instr_reg;
  logic [WORD_W-1:0] redirect_pc_reg;

  logic              redirect;
  logic [WORD_W-1:0] redirect_target;
  logic [WORD_W-1:0] pc_inc;

  // Branch comes from a later stage than jump, so it wins when both fire.
  assign redirect        = branch_taken | jump_en;
  assign redirect_target = branch_taken ? branch_target : jump_target;
  assign pc_inc          = pc_reg + PC_STEP;

  assign imem_req  = (state_reg == S_FETCH) || (state_reg == S_DROP);
  assign imem_addr = pc_reg;
  assign if_flush  = redirect && (state_reg != S_START);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg       <= S_START;
      pc_reg          <= RESET_PC;
      hold_instr_reg  <= '0;
      redirect_pc_reg <= '0;
      if_valid        <= 1'b0;
      if_instruction  <= NOP;
      if_pc4          <= '0;
    end else begin
      if_valid       <= 1'b0;
      if_instruction <= NOP;

      case (state_reg)
        S_START: begin
          state_reg <= S_FETCH;
        end

        S_FETCH: begin
          if (redirect) begin
            // The request in flight must still complete, so an unfinished
            // one is drained in S_DROP before fetching from the target.
            if (imem_ready) begin
              pc_reg <= redirect_target;
            end else begin
              redirect_pc_reg <= redirect_target;
              state_reg       <= S_DROP;
            end
          end else if (imem_ready) begin
            if (pc_write) begin
              if_instruction <= imem_rdata;
              if_pc4         <= pc_inc;
              if_valid       <= 1'b1;
              pc_reg         <= pc_inc;
            end else begin
              hold_instr_reg <= imem_rdata;
              state_reg      <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (redirect) begin
            pc_reg    <= redirect_target;
            state_reg <= S_FETCH;
          end else if (pc_write) begin
            if_instruction <= hold_instr_reg;
            if_pc4         <= pc_inc;
            if_valid       <= 1'b1;
            pc_reg         <= pc_inc;
            state_reg      <= S_FETCH;
          end
        end

        S_DROP: begin
          if (imem_ready) begin
            pc_reg    <= redirect ? redirect_target : redirect_pc_reg;
            state_reg <= S_FETCH;
          end else if (redirect) begin
            redirect_pc_reg <= redirect_target;
          end
        end

        default: begin
          state_reg <= S_START;
        end
      endcase
    end
  end

endmodule
